axi_stream_skid_slice_pack: RTL

- Backpressure-side counterpart to the forward retiming pack: a chain of REG_STAGES full-throughput skid-buffer stages.
- Registers both the forward path (tvalid/payload) and the backward path (tready), so no combinational path exists from axis_out_tready to axis_in_tready.
- Inserted on long AXI Stream routes in the virtualization shell, where tready timing, not data timing, limits Fmax.
- Sustains 1 beat/cycle under continuous flow.

---
 rtl/axis_slice_pkg.sv | 19 +
 rtl/axis_skid_stage.sv | 87 ++++++++
 rtl/axi_stream_skid_slice_pack.sv | 112 +++++++++++
 3 files changed

// File: rtl/axis_slice_pkg.sv
// Shared types and helpers for the AXI Stream skid slice.
package axis_slice_pkg;

    // Occupancy of one skid stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Width of the packed {tdata, tuser, tid, tdest, tkeep, tlast} vector.
    function automatic int unsigned axis_payload_width(input int unsigned bus,
                                                       input int unsigned tid,
                                                       input int unsigned tdest,
                                                       input int unsigned tuser);
        return bus + bus / 8 + tid + tdest + tuser + 1;
    endfunction

endpackage

// File: rtl/axis_skid_stage.sv
// One full-throughput skid-buffer stage. Both valid/data and ready are
// registered, so dn_ready never reaches up_ready combinationally.
module axis_skid_stage #(
    parameter int unsigned PAYLOAD_WIDTH = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [PAYLOAD_WIDTH-1:0] up_data,
    output logic                     dn_valid,
    input  logic                     dn_ready,
    output logic [PAYLOAD_WIDTH-1:0] dn_data
);
    import axis_slice_pkg::*;

    skid_state_t              state_q, state_d;
    logic                     rdy_q, rdy_d;
    logic [PAYLOAD_WIDTH-1:0] m_data_q, s_data_q;
    logic                     push, pop;
    logic                     load_main_in, load_main_skid, load_skid;

    assign push     = up_valid & rdy_q;
    assign pop      = (state_q != EMPTY) & dn_ready;
    assign up_ready = rdy_q;
    assign dn_valid = (state_q != EMPTY);
    assign dn_data  = m_data_q;

    // Next state and register load enables; ready follows the next skid occupancy.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d      = HALF;
                    load_main_in = 1'b1;
                end
            end
            HALF: begin
                if (push && pop) begin
                    load_main_in = 1'b1;
                end else if (push) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // rdy_q is low here, so no push can arrive.
                if (pop) begin
                    state_d        = HALF;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        rdy_d = (state_d != FULL);
    end

    // Control state; ready stays low through reset and rises on the first edge after.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
        end
    end

    // Payload registers carry no reset; their contents are qualified by state.
    always_ff @(posedge aclk) begin
        if (load_main_in) begin
            m_data_q <= up_data;
        end else if (load_main_skid) begin
            m_data_q <= s_data_q;
        end
        if (load_skid) begin
            s_data_q <= up_data;
        end
    end

endmodule

// File: rtl/axi_stream_skid_slice_pack.sv
// Chain of REG_STAGES skid stages on an AXI Stream link, cutting both the
// forward payload path and the backward tready path.
// Optional: define AXIS_SKID_SLICE_OCC_EN to add the occupancy output.
module axi_stream_skid_slice_pack #(
    parameter int unsigned AXIS_BUS_WIDTH   = 64,
    parameter int unsigned AXIS_TID_WIDTH   = 1,
    parameter int unsigned AXIS_TDEST_WIDTH = 1,
    parameter int unsigned AXIS_TUSER_WIDTH = 1,
    parameter int unsigned REG_STAGES       = 2,
    localparam int unsigned OCC_WIDTH =
        (REG_STAGES == 0) ? 1 : $clog2(2 * REG_STAGES + 1)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_tdata,
    input  logic [AXIS_TUSER_WIDTH-1:0]   axis_in_tuser,
    input  logic [AXIS_TID_WIDTH-1:0]     axis_in_tid,
    input  logic [AXIS_TDEST_WIDTH-1:0]   axis_in_tdest,
    input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_tkeep,
    input  logic                          axis_in_tlast,
    input  logic                          axis_in_tvalid,
    output logic                          axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]     axis_out_tdata,
    output logic [AXIS_TUSER_WIDTH-1:0]   axis_out_tuser,
    output logic [AXIS_TID_WIDTH-1:0]     axis_out_tid,
    output logic [AXIS_TDEST_WIDTH-1:0]   axis_out_tdest,
    output logic [AXIS_BUS_WIDTH/8-1:0]   axis_out_tkeep,
    output logic                          axis_out_tlast,
    output logic                          axis_out_tvalid,
    input  logic                          axis_out_tready
`ifdef AXIS_SKID_SLICE_OCC_EN
    ,
    output logic [OCC_WIDTH-1:0]          occupancy
`endif
);
    import axis_slice_pkg::*;

    localparam int unsigned PW = axis_payload_width(AXIS_BUS_WIDTH, AXIS_TID_WIDTH,
                                                    AXIS_TDEST_WIDTH, AXIS_TUSER_WIDTH);

    logic [PW-1:0] in_payload, out_payload;

    assign in_payload = {axis_in_tdata, axis_in_tuser, axis_in_tid, axis_in_tdest,
                         axis_in_tkeep, axis_in_tlast};
    assign {axis_out_tdata, axis_out_tuser, axis_out_tid, axis_out_tdest,
            axis_out_tkeep, axis_out_tlast} = out_payload;

    if (REG_STAGES == 0) begin : g_wire
        assign out_payload     = in_payload;
        assign axis_out_tvalid = axis_in_tvalid;
        assign axis_in_tready  = axis_out_tready;
    end else begin : g_chain
        logic          valid [REG_STAGES+1];
        logic          ready [REG_STAGES+1];
        logic [PW-1:0] data  [REG_STAGES+1];

        assign valid[0]             = axis_in_tvalid;
        assign data[0]              = in_payload;
        assign axis_in_tready       = ready[0];
        assign axis_out_tvalid      = valid[REG_STAGES];
        assign out_payload          = data[REG_STAGES];
        assign ready[REG_STAGES]    = axis_out_tready;

        for (genvar i = 0; i < REG_STAGES; i++) begin : g_stage
            axis_skid_stage #(
                .PAYLOAD_WIDTH(PW)
            ) u_stage (
                .aclk     (aclk),
                .aresetn  (aresetn),
                .up_valid (valid[i]),
                .up_ready (ready[i]),
                .up_data  (data[i]),
                .dn_valid (valid[i+1]),
                .dn_ready (ready[i+1]),
                .dn_data  (data[i+1])
            );
        end
    end

`ifdef AXIS_SKID_SLICE_OCC_EN
    if (REG_STAGES == 0) begin : g_occ_none
        assign occupancy = '0;
    end else begin : g_occ
        logic                 in_hs, out_hs;
        logic [OCC_WIDTH-1:0] occ_q, occ_d;

        assign in_hs     = axis_in_tvalid & axis_in_tready;
        assign out_hs    = axis_out_tvalid & axis_out_tready;
        assign occupancy = occ_q;

        // Count beats entering minus beats leaving the chain.
        always_comb begin
            occ_d = occ_q;
            if (in_hs && !out_hs) begin
                occ_d = occ_q + OCC_WIDTH'(1);
            end else if (!in_hs && out_hs) begin
                occ_d = occ_q - OCC_WIDTH'(1);
            end
        end

        // Occupancy register, cleared with the held beats on reset.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end
    end
`endif

endmodule
